// File: rtl/pwm_multi_ch_deadtime.sv
// N-channel complementary PWM generator with per-channel dead time and double-buffered settings.
// Define PWM_FAULT_EN to build the fault input synchroniser and gate-shutdown latch.
module pwm_multi_ch_deadtime #(
  parameter int CH   = 3,
  parameter int DW   = 15,
  parameter int DT_W = 8
) (
  input  logic              clk_dev,
  input  logic              reset,
  input  logic              enable,
  input  logic [DW-1:0]     period,
  input  logic [CH*DW-1:0]  duty,
  input  logic [DT_W-1:0]   dead_time,
  input  logic              center_mode,
  input  logic              update,
`ifdef PWM_FAULT_EN
  input  logic              fault_in,
  input  logic              fault_clr,
`endif
  output logic [CH-1:0]     pwm_p,
  output logic [CH-1:0]     pwm_n,
  output logic              period_end,
  output logic              update_ack,
  output logic              fault_active
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  typedef struct packed {
    logic [DW-1:0]    per;
    logic [CH*DW-1:0] duty;
    logic [DT_W-1:0]  dt;
    logic             cm;
  } cfg_t;

  cfg_t            act_q, act_d, shd_q, shd_d;
  logic            pend_q, pend_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  dir_e            dir_q, dir_d;
  logic [CH-1:0]   raw;
  logic [CH-1:0]   tgt_q, tgt_d;
  logic [CH-1:0]   live_q, live_d;
  logic [CH-1:0]   p_q, p_d;
  logic [CH-1:0]   n_q, n_d;
  logic [DT_W-1:0] dcnt_q [CH];
  logic [DT_W-1:0] dcnt_d [CH];
  logic            boundary;
  logic            apply;
  logic            fault_block;

  // Carrier boundary: top of the sawtooth, or the valley of the triangle.
  always_comb begin
    boundary   = act_q.cm ? (cnt_q == '0) : (cnt_q >= act_q.per);
    period_end = reset & enable & boundary;
    apply      = reset & pend_q & (period_end | ~enable);
    update_ack = apply;
  end

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!enable) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (!act_q.cm) begin
      dir_d = DIR_UP;
      cnt_d = (cnt_q >= act_q.per) ? '0 : cnt_q + 1'b1;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= act_q.per) begin
        // Turn around without repeating the peak; P<=1 degenerates to 0/1 toggling or a held 0.
        if (act_q.per <= DW'(1)) begin
          cnt_d = '0;
          dir_d = DIR_UP;
        end else begin
          cnt_d = act_q.per - 1'b1;
          dir_d = DIR_DOWN;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (cnt_q <= DW'(1)) begin
        cnt_d = '0;
        dir_d = DIR_UP;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // A later strobe overwrites the shadow; an apply and a new strobe in one cycle keep pending set.
  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    if (update) begin
      shd_d  = cfg_t'{period, duty, dead_time, center_mode};
      pend_d = 1'b1;
    end
  end

  // Dead-time path: a raw edge (or the first enabled cycle) forces both gates off for dt cycles.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      raw[i]    = act_q.duty[i*DW +: DW] > cnt_q;
      tgt_d[i]  = raw[i];
      live_d[i] = 1'b1;
      dcnt_d[i] = dcnt_q[i];
      p_d[i]    = 1'b0;
      n_d[i]    = 1'b0;
      if (!enable || fault_block) begin
        tgt_d[i]  = 1'b0;
        live_d[i] = 1'b0;
        dcnt_d[i] = '0;
      end else if (!live_q[i] || (raw[i] != tgt_q[i])) begin
        if (act_q.dt == '0) begin
          p_d[i]    = raw[i];
          n_d[i]    = ~raw[i];
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = act_q.dt - 1'b1;
        end
      end else if (dcnt_q[i] != '0) begin
        dcnt_d[i] = dcnt_q[i] - 1'b1;
      end else begin
        p_d[i] = tgt_q[i];
        n_d[i] = ~tgt_q[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_dev) begin
    if (!reset) begin
      act_q  <= '0;
      shd_q  <= '0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      tgt_q  <= '0;
      live_q <= '0;
      p_q    <= '0;
      n_q    <= '0;
      // NOTE: the dead counters are control state, not data storage, so the array is reset.
      for (int i = 0; i < CH; i++) dcnt_q[i] <= '0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      tgt_q  <= tgt_d;
      live_q <= live_d;
      p_q    <= p_d;
      n_q    <= n_d;
      for (int i = 0; i < CH; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  assign pwm_p = p_q;
  assign pwm_n = n_q;

`ifdef PWM_FAULT_EN
  logic [1:0] fsync_q, fsync_d;
  logic       flt_q, flt_d;

  // A live synchronised fault wins over a clear request.
  always_comb begin
    fsync_d = {fsync_q[0], fault_in};
    flt_d   = flt_q;
    if (fault_clr && !fsync_q[1]) flt_d = 1'b0;
    if (fsync_q[1]) flt_d = 1'b1;
  end

  always_ff @(posedge clk_dev) begin
    if (!reset) begin
      fsync_q <= '0;
      flt_q   <= 1'b0;
    end else begin
      fsync_q <= fsync_d;
      flt_q   <= flt_d;
    end
  end

  // Gating on the synchroniser output too saves a cycle versus waiting for the latch.
  assign fault_block  = fsync_q[1] | flt_q;
  assign fault_active = flt_q;
`else
  assign fault_block  = 1'b0;
  assign fault_active = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_multi_ch_deadtime.sv
// Directed bench: a table of carrier/duty/dead-time settings measured over whole periods,
// plus hand-written sequences for shadow updates, enable/reset, dead-time gaps and faults.
module tb_pwm_multi_ch_deadtime;
  localparam int CH   = 3;
  localparam int DW   = 15;
  localparam int DT_W = 8;

  logic              clk_dev = 1'b0;
  logic              reset;
  logic              enable;
  logic [DW-1:0]     period;
  logic [CH*DW-1:0]  duty;
  logic [DT_W-1:0]   dead_time;
  logic              center_mode;
  logic              update;
`ifdef PWM_FAULT_EN
  logic              fault_in;
  logic              fault_clr;
`endif
  logic [CH-1:0]     pwm_p;
  logic [CH-1:0]     pwm_n;
  logic              period_end;
  logic              update_ack;
  logic              fault_active;

  pwm_multi_ch_deadtime #(.CH(CH), .DW(DW), .DT_W(DT_W)) dut (
    .clk_dev     (clk_dev),
    .reset       (reset),
    .enable      (enable),
    .period      (period),
    .duty        (duty),
    .dead_time   (dead_time),
    .center_mode (center_mode),
    .update      (update),
`ifdef PWM_FAULT_EN
    .fault_in    (fault_in),
    .fault_clr   (fault_clr),
`endif
    .pwm_p       (pwm_p),
    .pwm_n       (pwm_n),
    .period_end  (period_end),
    .update_ack  (update_ack),
    .fault_active(fault_active)
  );

  always #5 clk_dev = ~clk_dev;

  int checks = 0;
  int errors = 0;
  int overlap_cycles = 0;

  always @(negedge clk_dev) if (|(pwm_p & pwm_n)) overlap_cycles++;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [DW-1:0]   per;
    logic [DW-1:0]   d0;
    logic [DT_W-1:0] dt;
    logic            cm;
    int              len;
    int              exp_p;
    int              exp_n;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_dev);
    #1;
  endtask

  // Ch1 is held at 0% and ch2 at 100% so channel slicing is exercised alongside ch0.
  task automatic configure(input logic [DW-1:0] per, input logic [DW-1:0] d0,
                           input logic [DT_W-1:0] dt, input logic cm, output logic ack);
    enable      = 1'b0;
    period      = per;
    duty        = {15'h7fff, 15'd0, d0};
    dead_time   = dt;
    center_mode = cm;
    update      = 1'b1;
    tick();
    update = 1'b0;
    ack    = update_ack;
    tick();
  endtask

  task automatic wait_pe(output bit found);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (period_end) found = 1'b1;
    end
  endtask

  // Waits for the watched ch0 gate to fall, then counts cycles with both ch0 gates low.
  task automatic measure_gap(input bit watch_p, output int gap, output bit found);
    logic prev, cur;
    found = 1'b0;
    gap   = 0;
    prev  = watch_p ? pwm_p[0] : pwm_n[0];
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      cur = watch_p ? pwm_p[0] : pwm_n[0];
      if (prev && !cur) found = 1'b1;
      prev = cur;
    end
    if (found) begin
      while (pwm_p[0] == 1'b0 && pwm_n[0] == 1'b0 && gap < 20) begin
        gap++;
        tick();
      end
    end
  endtask

  initial begin
    logic ack;
    bit   found;
    int   p_hi, n_hi, pe_cnt, p1_hi, n2_hi, ack_cnt, gap, first_gate, pe_tick;
    logic ack_at_end;

    // per, d0, dt, cm, period length, ch0 p-high and n-high cycles per period
    vecs[0] = '{15'd9, 15'd4,  8'd0, 1'b0, 10,  4,  6};
    vecs[1] = '{15'd8, 15'd3,  8'd0, 1'b1, 16,  5, 11}; // cnt 0,1,2 rising and 2,1 falling
    vecs[2] = '{15'd9, 15'd0,  8'd0, 1'b0, 10,  0, 10};
    vecs[3] = '{15'd9, 15'd10, 8'd0, 1'b0, 10, 10,  0};
    vecs[4] = '{15'd8, 15'd9,  8'd0, 1'b1, 16, 16,  0};
    vecs[5] = '{15'd0, 15'd1,  8'd0, 1'b0,  1,  1,  0};
    vecs[6] = '{15'd4, 15'd2,  8'd1, 1'b0,  5,  1,  2};
    vecs[7] = '{15'd6, 15'd3,  8'd2, 1'b1, 12,  3,  5};
    vecs[8] = '{15'd9, 15'd4,  8'd3, 1'b0, 10,  1,  3};
    vecs[9] = '{15'd9, 15'd1,  8'd3, 1'b0, 10,  0,  6}; // second raw edge inside dead time restarts it

    reset = 1'b0; enable = 1'b0; period = '0; duty = '0; dead_time = '0;
    center_mode = 1'b0; update = 1'b0;
`ifdef PWM_FAULT_EN
    fault_in = 1'b0; fault_clr = 1'b0;
`endif
    tick(); tick();
    check("reset_pwm_p", 32'(pwm_p), 0);
    check("reset_pwm_n", 32'(pwm_n), 0);
    check("reset_period_end", 32'(period_end), 0);
    check("reset_update_ack", 32'(update_ack), 0);
    check("reset_fault_active", 32'(fault_active), 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      configure(vecs[i].per, vecs[i].d0, vecs[i].dt, vecs[i].cm, ack);
      check($sformatf("row%0d_ack_disabled", i), 32'(ack), 1);
      enable = 1'b1;
      repeat (2 * vecs[i].len + 8) tick();
      p_hi = 0; n_hi = 0; pe_cnt = 0; p1_hi = 0; n2_hi = 0;
      for (int k = 0; k < 3 * vecs[i].len; k++) begin
        tick();
        p_hi   += int'(pwm_p[0]);
        n_hi   += int'(pwm_n[0]);
        pe_cnt += int'(period_end);
        p1_hi  += int'(pwm_p[1]);
        n2_hi  += int'(pwm_n[2]);
      end
      check($sformatf("row%0d_p_high", i), p_hi, 3 * vecs[i].exp_p);
      check($sformatf("row%0d_n_high", i), n_hi, 3 * vecs[i].exp_n);
      check($sformatf("row%0d_period_end", i), pe_cnt, 3);
      check($sformatf("row%0d_ch1_p_high", i), p1_hi, 0);
      check($sformatf("row%0d_ch2_n_high", i), n2_hi, 0);
    end

    // Exact dead-time gap on both transitions.
    configure(15'd9, 15'd4, 8'd3, 1'b0, ack);
    enable = 1'b1;
    repeat (30) tick();
    measure_gap(1'b1, gap, found);
    check("gap_p_fall_found", 32'(found), 1);
    check("gap_after_p_fall", gap, 3);
    measure_gap(1'b0, gap, found);
    check("gap_n_fall_found", 32'(found), 1);
    check("gap_after_n_fall", gap, 3);

    // Two mid-period updates: old duty holds to the wrap, only the last one is applied.
    configure(15'd9, 15'd4, 8'd0, 1'b0, ack);
    enable = 1'b1;
    repeat (25) tick();
    wait_pe(found);
    check("upd_sync_found", 32'(found), 1);
    p_hi = 0; ack_cnt = 0; ack_at_end = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        duty = {15'h7fff, 15'd0, 15'd7}; update = 1'b1;
      end else if (k == 5) begin
        duty = {15'h7fff, 15'd0, 15'd2}; update = 1'b1;
      end else begin
        update = 1'b0;
      end
      tick();
      p_hi    += int'(pwm_p[0]);
      ack_cnt += int'(update_ack);
      if (k == 9) ack_at_end = update_ack & period_end;
    end
    update = 1'b0;
    check("upd_old_duty_p_high", p_hi, 4);
    check("upd_ack_count", ack_cnt, 1);
    check("upd_ack_on_period_end", 32'(ack_at_end), 1);
    p_hi = 0; ack_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      p_hi    += int'(pwm_p[0]);
      ack_cnt += int'(update_ack);
    end
    check("upd_new_duty_p_high", p_hi, 2);
    check("upd_no_extra_ack", ack_cnt, 0);

    // Disable mid-period, then re-enable: carrier restarts at 0, first gate waits out dead time.
    configure(15'd9, 15'd4, 8'd2, 1'b0, ack);
    enable = 1'b1;
    repeat (25) tick();
    wait_pe(found);
    tick(); tick();
    enable = 1'b0;
    tick();
    check("disable_outputs_off", 32'({pwm_p, pwm_n}), 0);
    check("disable_no_period_end", 32'(period_end), 0);
    repeat (3) tick();
    enable = 1'b1;
    first_gate = 0; pe_tick = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (first_gate == 0 && (pwm_p[0] | pwm_n[0])) first_gate = t;
      if (pe_tick == 0 && period_end) pe_tick = t;
    end
    check("reenable_first_gate", first_gate, 3);
    check("reenable_first_period_end", pe_tick, 9);

    // Reset mid-period with an update pending: everything, including the pending update, is lost.
    duty = {15'h7fff, 15'd0, 15'd5};
    update = 1'b1;
    tick();
    update = 1'b0;
    reset = 1'b0;
    tick();
    check("midreset_outputs_off", 32'({pwm_p, pwm_n}), 0);
    check("midreset_period_end", 32'(period_end), 0);
    check("midreset_update_ack", 32'(update_ack), 0);
    reset = 1'b1;
    ack_cnt = 0; pe_cnt = 0; p_hi = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      ack_cnt += int'(update_ack);
      pe_cnt  += int'(period_end);
      p_hi    += int'(pwm_p[0]);
    end
    check("postreset_pending_lost", ack_cnt, 0);
    check("postreset_p0_period_end", pe_cnt, 3);
    check("postreset_p_low", p_hi, 0);

`ifdef PWM_FAULT_EN
    configure(15'd9, 15'd4, 8'd2, 1'b0, ack);
    enable = 1'b1;
    repeat (25) tick();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (pwm_p[0]) found = 1'b1;
    end
    check("fault_p_high_found", 32'(found), 1);
    fault_in = 1'b1;
    repeat (3) tick();
    check("fault_outputs_off", 32'({pwm_p, pwm_n}), 0);
    check("fault_active_set", 32'(fault_active), 1);
    fault_clr = 1'b1;
    repeat (2) tick();
    fault_clr = 1'b0;
    check("fault_clr_ignored", 32'(fault_active), 1);
    pe_cnt = 0; n_hi = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      pe_cnt += int'(period_end);
      n_hi   += int'(|{pwm_p, pwm_n});
    end
    check("fault_carrier_runs", pe_cnt, 2);
    check("fault_outputs_held_off", n_hi, 0);
    fault_in = 1'b0;
    repeat (3) tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("fault_cleared", 32'(fault_active), 0);
    first_gate = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (first_gate == 0 && (pwm_p[0] | pwm_n[0])) first_gate = t;
    end
    check("fault_resume_seen", 32'(first_gate != 0), 1);
    check("fault_resume_deadtime", 32'(first_gate >= 3), 1);
`endif

    check("p_n_overlap_cycles", overlap_cycles, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
